// File: rtl/gf32_shared_arith_arbiter_pkg.sv
// Shared types and constants for the GF/P251 arithmetic arbiter.
// Holds the FSM encoding, opcodes and the per-byte field multiply helpers.
package gf32_shared_arith_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_MUL   = 1'b1;
    localparam int   P251_MOD = 251;
    localparam int   MUL_LAT  = 2;

    // GF(2^8) multiply over the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf256_mul_8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] gf_mul_32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = gf256_mul_8(x[8*i +: 8], y[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [31:0] gf251_mul_32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] o;
        logic [15:0] p;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            p = 16'(x[8*i +: 8]) * 16'(y[8*i +: 8]);
            o[8*i +: 8] = 8'(p % 16'(P251_MOD));
        end
        return o;
    endfunction

endpackage

// File: rtl/gf32_shared_arith_arbiter_mul_unit.sv
// Two-stage 32-bit bytewise field multiplier shared by all lanes.
// o_done pulses MUL_LAT cycles after i_start, with o_o valid alongside.
module gf32_mul_unit
    import gf32_shared_arith_arbiter_pkg::*;
#(
    parameter string FIELD = "P251"
) (
    input  logic        i_clk,
    input  logic        i_start,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [31:0] o_o,
    output logic        o_done
);

    logic [31:0] prod;
    logic [31:0] prod_q;
    logic        vld_q;

    generate
        if (FIELD == "GF256") begin : g_gf256
            assign prod = gf_mul_32(i_x, i_y);
        end else begin : g_p251
            assign prod = gf251_mul_32(i_x, i_y);
        end
    endgenerate

    // No reset: the arbiter ignores o_done outside its own EXEC window.
    always_ff @(posedge i_clk) begin
        vld_q  <= i_start;
        o_done <= vld_q;
        o_o    <= prod_q;
        if (i_start) prod_q <= prod;
    end

endmodule

// File: rtl/gf32_shared_arith_arbiter.sv
// Round-robin arbiter granting N_REQ channels access to one lane-parallel adder
// and one shared multiplier, one operation at a time.
//   state    | meaning
//   ST_IDLE  | waiting for any request; grant + operand capture on exit
//   ST_LATCH | operands held, multiplier start armed for mul
//   ST_EXEC  | add in one cycle, or mul lane by lane through gf32_mul_unit
//   ST_RESP  | o_out updated, o_done pulses for the granted channel
module gf32_shared_arith_arbiter
    import gf32_shared_arith_arbiter_pkg::*;
#(
    parameter string FIELD = "P251",
    parameter int    N_REQ = 3,
    parameter int    LANES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_op,
    input  logic [N_REQ*32*LANES-1:0] i_in_1,
    input  logic [N_REQ*32*LANES-1:0] i_in_2,
    output logic [32*LANES-1:0]       o_out,
    output logic [N_REQ-1:0]          o_done,
    output logic                      o_busy
);

    localparam int W      = 32 * LANES;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t             state_q, state_nxt;
    logic [IDX_W-1:0]   ptr_q, gnt_q, pick_idx, cand;
    logic               pick_vld;
    logic               op_q;
    logic [W-1:0]       a_q, b_q, res_q, res_nxt, sum_w, out_q;
    logic [LANE_W-1:0]  lane_q;
    logic [N_REQ-1:0]   done_q;
    logic               mul_start_q, mul_start_nxt, lane_store;
    logic [31:0]        mul_x, mul_y, mul_o;
    logic               mul_done;

    // Highest offset first so the lowest offset from the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (i_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    generate
        for (genvar g = 0; g < 4 * LANES; g++) begin : g_byte
            logic [7:0] a, b;
            assign a = a_q[8*g +: 8];
            assign b = b_q[8*g +: 8];
            if (FIELD == "GF256") begin : g_xor
                assign sum_w[8*g +: 8] = a ^ b;
            end else begin : g_mod
                logic [8:0] s;
                assign s = {1'b0, a} + {1'b0, b};
                assign sum_w[8*g +: 8] = (s >= 9'(P251_MOD)) ? 8'(s - 9'(P251_MOD)) : s[7:0];
            end
        end
    endgenerate

    assign mul_x = a_q[lane_q*32 +: 32];
    assign mul_y = b_q[lane_q*32 +: 32];

    gf32_mul_unit #(.FIELD(FIELD)) u_mul (
        .i_clk   (i_clk),
        .i_start (mul_start_q),
        .i_x     (mul_x),
        .i_y     (mul_y),
        .o_o     (mul_o),
        .o_done  (mul_done)
    );

    always_comb begin
        res_nxt = res_q;
        res_nxt[lane_q*32 +: 32] = mul_o;
    end

    always_comb begin
        state_nxt     = state_q;
        mul_start_nxt = 1'b0;
        lane_store    = 1'b0;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_nxt = ST_LATCH;
            ST_LATCH: begin
                state_nxt     = ST_EXEC;
                mul_start_nxt = (op_q == OP_MUL);
            end
            ST_EXEC: begin
                if (op_q == OP_ADD) begin
                    state_nxt = ST_RESP;
                end else if (mul_done) begin
                    lane_store = 1'b1;
                    if (lane_q == LANE_W'(LANES - 1)) state_nxt = ST_RESP;
                    else mul_start_nxt = 1'b1;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q       <= '0;
            lane_q      <= '0;
            mul_start_q <= 1'b0;
            done_q      <= '0;
            out_q       <= '0;
        end else begin
            mul_start_q <= mul_start_nxt;
            done_q      <= '0;
            if (state_q == ST_IDLE && pick_vld) begin
                gnt_q  <= pick_idx;
                op_q   <= i_op[pick_idx];
                a_q    <= i_in_1[pick_idx*W +: W];
                b_q    <= i_in_2[pick_idx*W +: W];
                ptr_q  <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                lane_q <= '0;
            end
            if (lane_store) begin
                res_q  <= res_nxt;
                lane_q <= lane_q + 1'b1;
            end
            if (state_q == ST_EXEC && state_nxt == ST_RESP) begin
                out_q  <= (op_q == OP_ADD) ? sum_w : res_nxt;
                done_q <= N_REQ'(1) << gnt_q;
            end
        end
    end

    assign o_out  = out_q;
    assign o_done = done_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule
